// File: rtl/rtf65002_icache_pkg.sv
// rtf65002_icache_pkg: shared state encoding and bus constants for the I-cache fill controller
package rtf65002_icache_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_SETTLE,
        S_INV
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int LINE_WORDS = 4;
    localparam int TAG_LINES  = 256;

endpackage

// File: rtl/rtf65002_icachefill.sv
// rtf65002_icachefill: I-cache miss handler, 4-word Wishbone line fill; ICACHE_INVALIDATE_EN adds invalidate-all
module rtf65002_icachefill
    import rtf65002_icache_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int BURST_EN      = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [31:0] pc_i,
    input  logic        hit0_i,
    input  logic        hit1_i,
    input  logic        inv_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [2:0]  cti_o,
    output logic [1:0]  bte_o,
    output logic [33:0] adr_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic [31:0] dat_i,
    output logic        wr_o,
    output logic [33:0] wadr_o,
    output logic [31:0] wdat_o,
    output logic        busy_o,
    output logic        ierr_o
);

    state_t      r_state, w_next;
    logic [31:0] r_rpc;
    logic        r_rreq;
    logic [27:0] r_base;
    logic [1:0]  r_cnt;
    logic [7:0]  r_scnt;
    logic [7:0]  r_idx;
    logic        r_wr;
    logic [33:0] r_wadr;
    logic [31:0] r_wdat;
    logic        r_ierr;
    logic [31:0] w_rpc8;
    logic        w_miss0, w_miss1, w_ack, w_err, w_inv, w_fill;

`ifdef ICACHE_INVALIDATE_EN
    assign w_inv = inv_i;
`else
    logic w_unused_inv;
    assign w_unused_inv = inv_i;
    assign w_inv        = 1'b0;
`endif

    assign w_rpc8  = r_rpc + 32'd8;
    assign w_miss0 = r_rreq && !hit0_i;
    assign w_miss1 = r_rreq && !hit1_i;
    assign w_fill  = r_state == S_FILL;
    // err_i beats a simultaneous ack_i so a faulted word is never written
    assign w_ack   = w_fill && ack_i && !err_i;
    assign w_err   = w_fill && err_i;

    assign cyc_o  = w_fill;
    assign stb_o  = w_fill;
    assign bte_o  = 2'b00;
    assign cti_o  = (w_fill && BURST_EN != 0) ? ((r_cnt == 2'(LINE_WORDS - 1)) ? CTI_EOB : CTI_INCR) : CTI_CLASSIC;
    assign adr_o  = w_fill ? {2'b00, r_base, r_cnt, 2'b00} : 34'h0;
    assign busy_o = r_state != S_IDLE;
    assign wr_o   = r_wr;
    assign wadr_o = r_wadr;
    assign wdat_o = r_wdat;
    assign ierr_o = r_ierr;

    // next-state selection
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_inv ? S_INV : (w_miss0 || w_miss1) ? S_FILL : S_IDLE;
            S_FILL:   w_next = (w_err || (w_ack && r_cnt == 2'(LINE_WORDS - 1))) ? S_SETTLE : S_FILL;
            S_SETTLE: w_next = (r_scnt == 8'(SETTLE_CYCLES - 1)) ? S_IDLE : S_SETTLE;
            S_INV:    w_next = (r_idx == 8'(TAG_LINES - 1)) ? S_SETTLE : S_INV;
            default:  w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // fetch alignment, fill counters, registered cache write port and sticky error
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rpc  <= 32'h0;
            r_rreq <= 1'b0;
            r_base <= 28'h0;
            r_cnt  <= 2'd0;
            r_scnt <= 8'd0;
            r_idx  <= 8'd0;
            r_wr   <= 1'b0;
            r_wadr <= 34'h0;
            r_wdat <= 32'h0;
            r_ierr <= 1'b0;
        end else begin
            r_rpc  <= pc_i;
            r_rreq <= req_i;
            r_wr   <= w_ack;
            if (r_state == S_IDLE) begin
                r_cnt  <= 2'd0;
                r_scnt <= 8'd0;
                r_idx  <= 8'd0;
                r_base <= w_miss0 ? r_rpc[31:4] : w_rpc8[31:4];
            end
            if (w_ack) begin
                r_wadr <= {2'b00, r_base, r_cnt, 2'b01};
                r_wdat <= dat_i;
                r_cnt  <= r_cnt + 2'd1;
            end
            if (r_state == S_SETTLE)
                r_scnt <= r_scnt + 8'd1;
            if (r_state == S_INV) begin
                r_wr   <= 1'b1;
                r_wadr <= {22'h0, r_idx, 4'b1100};
                r_idx  <= r_idx + 8'd1;
            end
            if (w_err)
                r_ierr <= 1'b1;
            else if (r_state == S_IDLE && r_rreq && hit0_i && hit1_i)
                r_ierr <= 1'b0;
        end
    end

endmodule
